// File: rtl/pitch_pkg.sv
// pitch_pkg: note period bounds and classifier FSM states shared by pitch_detect.
package pitch_pkg;
    localparam int NUM_NOTES = 32;

    typedef enum logic [1:0] {S_WAIT, S_CLASSIFY, S_DECIDE} state_t;

    // bound[k] = floor(400 * 2^(-k/12)), descending: shortest accepted period per note
    localparam logic [15:0] BOUND [NUM_NOTES] = '{
        16'd400, 16'd377, 16'd356, 16'd336, 16'd317, 16'd299, 16'd282, 16'd266,
        16'd251, 16'd237, 16'd224, 16'd211, 16'd200, 16'd188, 16'd178, 16'd168,
        16'd158, 16'd149, 16'd141, 16'd133, 16'd125, 16'd118, 16'd112, 16'd105,
        16'd100, 16'd94,  16'd89,  16'd84,  16'd79,  16'd74,  16'd70,  16'd66
    };
endpackage

// File: rtl/pitch_bound_rom.sv
// pitch_bound_rom: combinational lookup of the lower period bound for a note index.
module pitch_bound_rom
    import pitch_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic [4:0]          idx,
    output logic [PERIOD_W-1:0] bound
);
    assign bound = PERIOD_W'(BOUND[idx]);
endmodule

// File: rtl/pitch_detect.sv
// pitch_detect: recovers the note index from an audio level stream by timing
// hysteretic rising mid-level crossings and classifying the period against the note table.
module pitch_detect
    import pitch_pkg::*;
#(
    parameter int BITS     = 6,
    parameter int HYST     = 2,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            sample_valid,
    input  logic [BITS-1:0] level,
    output logic [4:0]      freq_id,
    output logic            new_f,
    output logic            tone_present
);
    localparam int HI = 2 ** (BITS - 1) + HYST;
    localparam int LO = 2 ** (BITS - 1) - HYST;

    state_t              state;
    logic                phase;
    logic                armed;
    logic                cand_valid;
    logic                oor;
    logic [4:0]          cand;
    logic [4:0]          idx;
    logic [PERIOD_W-1:0] count;
    logic [PERIOD_W-1:0] count_inc;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] bound;
    logic                rise;
    logic                timeout;

    pitch_bound_rom #(.PERIOD_W(PERIOD_W)) u_rom (.idx(idx), .bound(bound));

    assign count_inc = &count ? count : count + 1'b1;
    assign rise      = sample_valid && !phase && int'(level) >= HI;
    assign timeout   = sample_valid && !rise && count == PERIOD_W'(TIMEOUT - 1);

    // count holds samples since the last rising edge, so the period ending on an edge is count+1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_WAIT;
            phase        <= 1'b0;
            armed        <= 1'b0;
            cand_valid   <= 1'b0;
            oor          <= 1'b0;
            cand         <= '0;
            idx          <= '0;
            count        <= '0;
            period       <= '0;
            freq_id      <= '0;
            new_f        <= 1'b0;
            tone_present <= 1'b0;
        end else begin
            new_f <= 1'b0;
            if (sample_valid) begin
                phase <= phase ? int'(level) > LO : int'(level) >= HI;
                count <= rise ? '0 : count_inc;
            end
            if (rise)
                armed <= 1'b1;
            case (state)
                S_WAIT: begin
                    if (rise && armed) begin
                        period <= count_inc;
                        idx    <= '0;
                        state  <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    if (period >= bound) begin
                        oor   <= 1'b0;
                        state <= S_DECIDE;
                    end else if (&idx) begin
                        oor   <= 1'b1;
                        state <= S_DECIDE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DECIDE: begin
                    state <= S_WAIT;
                    if (oor) begin
                        tone_present <= 1'b0;
                        cand_valid   <= 1'b0;
                    end else if (cand_valid && idx == cand && (idx != freq_id || !tone_present)) begin
                        freq_id      <= idx;
                        tone_present <= 1'b1;
                        new_f        <= 1'b1;
                    end else begin
                        cand       <= idx;
                        cand_valid <= 1'b1;
                    end
                end
                default: state <= S_WAIT;
            endcase
            if (timeout) begin
                tone_present <= 1'b0;
                armed        <= 1'b0;
                cand_valid   <= 1'b0;
            end
        end
    end
endmodule
